// File: rtl/otp_block_sequencer.sv
// otp_block_sequencer: XORs one SD block of received nibbles with pad nibbles
// into the send RAM, owning both RAM address buses during a pass.
//   istart/iabort          : pass control from the SD controller
//   ootp_req/iotp_valid/
//   iotp/ootp_ack          : pad generator stream
//   oraddr/irdata          : received-data RAM read port (1-cycle latency)
//   owaddr/owdata/owe      : send RAM write port
//   obusy/odone/ofail      : status; odone/ofail are 1-cycle pulses
module otp_block_sequencer #(
   parameter int AW      = 10,
   parameter int NIBBLES = 1024,
   parameter int TIMEOUT = 4095
) (
   input  logic          iclk,
   input  logic          irst,
   input  logic          istart,
   input  logic          iabort,
   output logic          ootp_req,
   input  logic          iotp_valid,
   input  logic [3:0]    iotp,
   output logic          ootp_ack,
   output logic [AW-1:0] oraddr,
   input  logic [3:0]    irdata,
   output logic [AW-1:0] owaddr,
   output logic [3:0]    owdata,
   output logic          owe,
   output logic          obusy,
   output logic          odone,
   output logic          ofail
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] LAST = AW'(NIBBLES - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      PROC,
      DRAIN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] to_q, to_d;
   logic          s1_v_q, s1_v_d;
   logic [AW-1:0] s1_addr_q, s1_addr_d;
   logic [3:0]    s1_otp_q, s1_otp_d;
   logic          abort;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      to_d      = to_q;
      s1_v_d    = 1'b0;
      s1_addr_d = s1_addr_q;
      s1_otp_d  = s1_otp_q;
      ootp_req  = 1'b0;
      ootp_ack  = 1'b0;
      oraddr    = '0;
      odone     = 1'b0;
      ofail     = 1'b0;
      abort     = iabort && (state_q != IDLE);

      // Stage-1 write lands the cycle after its ack; an abort drops it.
      owe    = s1_v_q && !abort;
      owaddr = owe ? s1_addr_q : '0;
      owdata = owe ? (irdata ^ s1_otp_q) : '0;
      obusy  = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (istart && !iabort) begin
               state_d = PROC;
               cnt_d   = '0;
               to_d    = '0;
            end
         end
         PROC: begin
            ootp_req = 1'b1;
            oraddr   = cnt_q;
            if (abort) begin
               state_d = IDLE;
            end else if (iotp_valid) begin
               ootp_ack  = 1'b1;
               s1_v_d    = 1'b1;
               s1_addr_d = cnt_q;
               s1_otp_d  = iotp;
               cnt_d     = cnt_q + AW'(1);
               to_d      = '0;
               if (cnt_q == LAST) state_d = DRAIN;
            end else if (to_q == TO_LAST) begin
               ofail   = 1'b1;
               state_d = IDLE;
               to_d    = '0;
            end else begin
               to_d = to_q + TW'(1);
            end
         end
         DRAIN: begin
            state_d = abort ? IDLE : DONE;
         end
         DONE: begin
            odone   = !abort;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iclk or negedge irst) begin
      if (!irst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         to_q      <= '0;
         s1_v_q    <= 1'b0;
         s1_addr_q <= '0;
         s1_otp_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         to_q      <= to_d;
         s1_v_q    <= s1_v_d;
         s1_addr_q <= s1_addr_d;
         s1_otp_q  <= s1_otp_d;
      end
   end

endmodule
